svga_sync_decoder: RTL and testbench
====================================

Name: svga_sync_decoder

Overview:
- Receive-side counterpart of the SVGA video interface: consumes the COLOR/HSYNC/VSYNC stream a renderer drives and recovers pixel coordinates, a pixel-valid strobe and the pixel colour.
- Checks line and frame timing against the 800x600 SVGA mode and reports lock and timing errors.
- Used as a bench monitor and for frame capture; sits on the output side of the renderer, in the same clock domain.

Parameters:
- H_VISIBLE, 800, visible pixels per line
- H_SYNC, 120, HSYNC pulse width in clocks
- H_BP, 64, horizontal back porch in clocks
- H_TOTAL, 1040, clocks per line
- V_VISIBLE, 600, visible lines per frame
- V_SYNC, 6, VSYNC pulse width in lines
- V_BP, 23, vertical back porch in lines
- V_TOTAL, 666, lines per frame

Ports:
- CLK  input  1  pixel clock, rising edge
- RESET  input  1  asynchronous, active-high reset
- COLOR_IN  input  8  pixel colour from the video interface
- HSYNC_IN  input  1  horizontal sync, active high
- VSYNC_IN  input  1  vertical sync, active high
- X_PIXEL  output  10  recovered column, 0..H_VISIBLE-1
- Y_PIXEL  output  10  recovered row, 0..V_VISIBLE-1
- PIXEL_VALID  output  1  high when X/Y/COLOR_OUT denote a visible pixel
- COLOR_OUT  output  8  colour aligned with X/Y
- LINE_START  output  1  one-cycle pulse at each detected HSYNC rise
- FRAME_START  output  1  one-cycle pulse when the vertical counter realigns
- LOCKED  output  1  timing verified, valid output enabled
- H_ERR  output  1  one-cycle pulse on a bad line period
- V_ERR  output  1  one-cycle pulse on a bad frame period

Behaviour:
- Reset (async, active-high): all outputs 0; all counters 0; line_seen, frame_seen and vsync_pending cleared; sync history registers 0.
- Input stage: COLOR_IN, HSYNC_IN and VSYNC_IN are registered once. Edge detection compares against the previous registered value.
- hcnt (11 bit):
  - On an HSYNC rise, hcnt <= 0.
  - Otherwise hcnt increments, saturating at 2047.
- H check, at each HSYNC rise:
  - If line_seen and hcnt != H_TOTAL-1, pulse H_ERR.
  - Then set line_seen.
  - LINE_START pulses on every HSYNC rise.
- vsync_pending: set on a VSYNC rise.
- vcnt (10 bit), updated on each HSYNC rise:
  - If vsync_pending is set, or a VSYNC rise occurs in the same cycle: vcnt <= 0, clear vsync_pending, pulse FRAME_START.
  - Otherwise vcnt increments, saturating at 1023.
  - vcnt never changes between HSYNC rises.
- V check, at each realignment:
  - If frame_seen and the pre-reset vcnt != V_TOTAL-1, pulse V_ERR.
  - Then set frame_seen.
- Lock:
  - LOCKED rises at a realignment that passes the V check (frame_seen already set) with no H_ERR since the previous realignment.
  - LOCKED falls in the same cycle that H_ERR or V_ERR is asserted.
  - After a fall, relocking requires another full clean frame.
- Active window: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_VISIBLE) and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_VISIBLE).
- Outputs:
  - PIXEL_VALID = window AND LOCKED.
  - X_PIXEL = hcnt-(H_SYNC+H_BP); Y_PIXEL = vcnt-(V_SYNC+V_BP), truncated to 10 bits.
  - COLOR_OUT is the colour sample for that position.
  - Outside the valid window, X/Y/COLOR_OUT hold 0.
- Latency: output registers update 2 clocks after the input edge carrying the sample. LINE_START, FRAME_START, H_ERR and V_ERR share that alignment.
- Saturation: a missing HSYNC freezes hcnt at 2047. The next rise then flags H_ERR. No wrap-around.
- Simultaneous H_ERR and V_ERR: both pulse; LOCKED clears once.
- Reset mid-frame: immediate output clear. Relock needs two VSYNC-aligned realignments with one clean frame between them.

Test Plan:
- Clean timing from reset, 3 frames:
  - no H_ERR/V_ERR;
  - LOCKED rises at the 2nd FRAME_START;
  - PIXEL_VALID is low throughout frame 1.
- Locked frame, first visible pixel: at hcnt=184, vcnt=29, 2 clocks after the input, PIXEL_VALID=1, X=0, Y=0, COLOR_OUT=input colour (e.g. 8'hA5). The last pixel gives X=799, Y=599. Exactly 480000 valid strobes per frame.
- One line shortened to 1039 clocks while locked:
  - H_ERR pulses once at the next HSYNC rise;
  - LOCKED drops in the same cycle;
  - relock at the 2nd clean frame boundary after the error.
- Frame of 665 lines while locked: V_ERR and LOCKED drop at realignment. HSYNC held low 3000 clocks: hcnt saturates, then H_ERR fires on the next rise.
- VSYNC rising mid-line (hcnt=500): FRAME_START and vcnt=0 occur only at the following HSYNC rise. VSYNC rising coincident with HSYNC realigns in that same cycle.
- RESET asserted at X=400, Y=300: all outputs 0 asynchronously. After release, with clean input, LOCKED returns at the 2nd FRAME_START.

Source files
------------

// File: rtl/svga_sync_decoder_if.sv
// Signal bundle between an SVGA video source and the sync decoder: the raw colour/sync
// stream in, recovered coordinates, pixel strobe and timing status out.
interface svga_sync_decoder_if;
  logic [7:0] COLOR_IN;
  logic       HSYNC_IN;
  logic       VSYNC_IN;
  logic [9:0] X_PIXEL;
  logic [9:0] Y_PIXEL;
  logic       PIXEL_VALID;
  logic [7:0] COLOR_OUT;
  logic       LINE_START;
  logic       FRAME_START;
  logic       LOCKED;
  logic       H_ERR;
  logic       V_ERR;

  modport master (
    output COLOR_IN, HSYNC_IN, VSYNC_IN,
    input  X_PIXEL, Y_PIXEL, PIXEL_VALID, COLOR_OUT,
    input  LINE_START, FRAME_START, LOCKED, H_ERR, V_ERR
  );

  modport slave (
    input  COLOR_IN, HSYNC_IN, VSYNC_IN,
    output X_PIXEL, Y_PIXEL, PIXEL_VALID, COLOR_OUT,
    output LINE_START, FRAME_START, LOCKED, H_ERR, V_ERR
  );
endinterface

// File: rtl/svga_sync_decoder.sv
// Receive-side SVGA timing recovery: rebuilds pixel coordinates from HSYNC/VSYNC, checks
// line and frame periods, and only strobes pixels once a full clean frame has been seen.
module svga_sync_decoder #(
  parameter int unsigned H_VISIBLE = 800,
  parameter int unsigned H_SYNC    = 120,
  parameter int unsigned H_BP      = 64,
  parameter int unsigned H_TOTAL   = 1040,
  parameter int unsigned V_VISIBLE = 600,
  parameter int unsigned V_SYNC    = 6,
  parameter int unsigned V_BP      = 23,
  parameter int unsigned V_TOTAL   = 666
) (
  input logic                CLK,
  input logic                RESET,
  svga_sync_decoder_if.slave bus
);

  localparam logic [10:0] HStart = 11'(H_SYNC + H_BP);
  localparam logic [10:0] HEnd   = 11'(H_SYNC + H_BP + H_VISIBLE);
  localparam logic [10:0] HLast  = 11'(H_TOTAL - 1);
  localparam logic [10:0] HMax   = 11'h7FF;
  localparam logic [9:0]  VStart = 10'(V_SYNC + V_BP);
  localparam logic [9:0]  VEnd   = 10'(V_SYNC + V_BP + V_VISIBLE);
  localparam logic [9:0]  VLast  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VMax   = 10'h3FF;

  // Input stage and sync history
  logic [7:0] colorQ;
  logic       hsyncQ, vsyncQ, hsyncPrevQ, vsyncPrevQ;

  // Timing state
  logic [10:0] hCntQ, hCntD;
  logic [9:0]  vCntQ, vCntD;
  logic        lineSeenQ, lineSeenD;
  logic        frameSeenQ, frameSeenD;
  logic        vsyncPendingQ, vsyncPendingD;
  logic        dirtyQ, dirtyD;
  logic        lockedQ, lockedD;

  // Output registers
  logic [9:0] xQ, xD, yQ, yD;
  logic [7:0] colorOutQ, colorOutD;
  logic       validQ, validD;
  logic       lineStartQ, frameStartQ, hErrQ, vErrQ;

  logic hRise, vRise, realign, hErr, vErr, inWindow;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      colorQ     <= '0;
      hsyncQ     <= 1'b0;
      vsyncQ     <= 1'b0;
      hsyncPrevQ <= 1'b0;
      vsyncPrevQ <= 1'b0;
    end else begin
      colorQ     <= bus.COLOR_IN;
      hsyncQ     <= bus.HSYNC_IN;
      vsyncQ     <= bus.VSYNC_IN;
      hsyncPrevQ <= hsyncQ;
      vsyncPrevQ <= vsyncQ;
    end
  end

  always_comb begin
    hRise   = hsyncQ & ~hsyncPrevQ;
    vRise   = vsyncQ & ~vsyncPrevQ;
    // A VSYNC rise only takes effect on a line boundary, so vcnt stays line-granular.
    realign = hRise & (vsyncPendingQ | vRise);
    hErr    = hRise & lineSeenQ & (hCntQ != HLast);
    vErr    = realign & frameSeenQ & (vCntQ != VLast);
  end

  always_comb begin
    hCntD = hCntQ;
    if (hRise) begin
      hCntD = '0;
    end else if (hCntQ != HMax) begin
      hCntD = hCntQ + 11'd1;
    end

    vCntD = vCntQ;
    if (realign) begin
      vCntD = '0;
    end else if (hRise && (vCntQ != VMax)) begin
      vCntD = vCntQ + 10'd1;
    end
  end

  always_comb begin
    lineSeenD     = lineSeenQ | hRise;
    frameSeenD    = frameSeenQ | realign;
    vsyncPendingD = realign ? 1'b0 : (vsyncPendingQ | vRise);
    // Tracks H errors inside the frame that is about to end at the next realignment.
    dirtyD        = realign ? 1'b0 : (dirtyQ | hErr);

    lockedD = lockedQ;
    if (hErr || vErr) begin
      lockedD = 1'b0;
    end else if (realign && frameSeenQ && !dirtyQ) begin
      lockedD = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      hCntQ         <= '0;
      vCntQ         <= '0;
      lineSeenQ     <= 1'b0;
      frameSeenQ    <= 1'b0;
      vsyncPendingQ <= 1'b0;
      dirtyQ        <= 1'b0;
      lockedQ       <= 1'b0;
    end else begin
      hCntQ         <= hCntD;
      vCntQ         <= vCntD;
      lineSeenQ     <= lineSeenD;
      frameSeenQ    <= frameSeenD;
      vsyncPendingQ <= vsyncPendingD;
      dirtyQ        <= dirtyD;
      lockedQ       <= lockedD;
    end
  end

  // hCntD/vCntD are the position of the sample now sitting in the input stage.
  always_comb begin
    inWindow = (hCntD >= HStart) && (hCntD < HEnd) && (vCntD >= VStart) && (vCntD < VEnd);
    validD   = inWindow & lockedD;
    xD        = '0;
    yD        = '0;
    colorOutD = '0;
    if (validD) begin
      xD        = 10'(hCntD - HStart);
      yD        = vCntD - VStart;
      colorOutD = colorQ;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      xQ          <= '0;
      yQ          <= '0;
      colorOutQ   <= '0;
      validQ      <= 1'b0;
      lineStartQ  <= 1'b0;
      frameStartQ <= 1'b0;
      hErrQ       <= 1'b0;
      vErrQ       <= 1'b0;
    end else begin
      xQ          <= xD;
      yQ          <= yD;
      colorOutQ   <= colorOutD;
      validQ      <= validD;
      lineStartQ  <= hRise;
      frameStartQ <= realign;
      hErrQ       <= hErr;
      vErrQ       <= vErr;
    end
  end

  assign bus.X_PIXEL     = xQ;
  assign bus.Y_PIXEL     = yQ;
  assign bus.COLOR_OUT   = colorOutQ;
  assign bus.PIXEL_VALID = validQ;
  assign bus.LINE_START  = lineStartQ;
  assign bus.FRAME_START = frameStartQ;
  assign bus.LOCKED      = lockedQ;
  assign bus.H_ERR       = hErrQ;
  assign bus.V_ERR       = vErrQ;

endmodule

// File: tb/tb_svga_sync_decoder.sv
// Bench for svga_sync_decoder on a shrunk video mode: a frame generator pushes every pixel
// it expects to see strobed, and a negedge monitor pops and compares them.
module tb_svga_sync_decoder;

  localparam int HVis   = 8;
  localparam int HSync  = 2;
  localparam int HBp    = 3;
  localparam int HTot   = 16;
  localparam int VVis   = 6;
  localparam int VSync  = 1;
  localparam int VBp    = 2;
  localparam int VTot   = 12;
  localparam int HStart = HSync + HBp;
  localparam int VStart = VSync + VBp;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] c;
    int         launch;
  } pix_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;

  svga_sync_decoder_if bus ();

  svga_sync_decoder #(
    .H_VISIBLE(HVis),
    .H_SYNC   (HSync),
    .H_BP     (HBp),
    .H_TOTAL  (HTot),
    .V_VISIBLE(VVis),
    .V_SYNC   (VSync),
    .V_BP     (VBp),
    .V_TOTAL  (VTot)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  int   cycle = 0;
  int   assertCount = 0;
  int   failCount = 0;
  pix_t pixQ[$];

  int   frameStartCount = 0, lineStartCount = 0, hErrCount = 0, vErrCount = 0;
  int   validCount = 0, lockRiseFrame = 0, lastFrameStartCycle = 0, frameLaunch = 0;
  logic lockedPrev = 1'b0;
  bit   firstSeen = 1'b0;
  logic [9:0] firstX, firstY, lastX, lastY;
  logic [7:0] firstColor;

  always @(posedge CLK) cycle <= cycle + 1;

  // Monitor: event counters, lock rules and scoreboard pops.
  always @(negedge CLK) begin
    pix_t e;
    if (RESET) begin
      lockedPrev = 1'b0;
    end else begin
      if (bus.FRAME_START === 1'b1) begin
        frameStartCount++;
        lastFrameStartCycle = cycle;
      end
      if (bus.LINE_START === 1'b1) lineStartCount++;
      if (bus.H_ERR === 1'b1) hErrCount++;
      if (bus.V_ERR === 1'b1) vErrCount++;
      if (bus.H_ERR === 1'b1 || bus.V_ERR === 1'b1) begin
        assertCount++;
        if (bus.LOCKED !== 1'b0) begin
          failCount++;
          $display("FAIL lock_drop_on_err: LOCKED=%b required 0 at cycle %0d", bus.LOCKED, cycle);
        end
      end
      if (bus.LOCKED === 1'b1 && lockedPrev !== 1'b1) begin
        lockRiseFrame = frameStartCount;
        assertCount++;
        if (bus.FRAME_START !== 1'b1) begin
          failCount++;
          $display("FAIL lock_rise_align: FRAME_START=%b required 1 at cycle %0d",
                   bus.FRAME_START, cycle);
        end
      end
      lockedPrev = bus.LOCKED;
      assertCount++;
      if (bus.PIXEL_VALID === 1'b1) begin
        validCount++;
        if (!firstSeen) begin
          firstSeen  = 1'b1;
          firstX     = bus.X_PIXEL;
          firstY     = bus.Y_PIXEL;
          firstColor = bus.COLOR_OUT;
        end
        lastX = bus.X_PIXEL;
        lastY = bus.Y_PIXEL;
        if (pixQ.size() == 0) begin
          failCount++;
          $display("FAIL pixel_unexpected: x=%0d y=%0d required no strobe at cycle %0d",
                   bus.X_PIXEL, bus.Y_PIXEL, cycle);
        end else begin
          e = pixQ.pop_front();
          if (bus.X_PIXEL !== e.x || bus.Y_PIXEL !== e.y || bus.COLOR_OUT !== e.c ||
              cycle - e.launch != 2) begin
            failCount++;
            $display("FAIL pixel: x=%0d y=%0d c=%h lat=%0d required x=%0d y=%0d c=%h lat=2",
                     bus.X_PIXEL, bus.Y_PIXEL, bus.COLOR_OUT, cycle - e.launch, e.x, e.y, e.c);
          end
        end
      end else if ({bus.X_PIXEL, bus.Y_PIXEL, bus.COLOR_OUT} !== 28'd0 ||
                   bus.PIXEL_VALID !== 1'b0) begin
        failCount++;
        $display("FAIL idle_outputs: valid=%b x=%0d y=%0d c=%h required all 0 at cycle %0d",
                 bus.PIXEL_VALID, bus.X_PIXEL, bus.Y_PIXEL, bus.COLOR_OUT, cycle);
      end
    end
  end

  task automatic drive(input logic hs, input logic vs, input logic [7:0] col);
    @(posedge CLK);
    #1;
    bus.HSYNC_IN = hs;
    bus.VSYNC_IN = vs;
    bus.COLOR_IN = col;
  endtask

  // One frame of stimulus; visible pixels are pushed as expectations while expValid holds.
  task automatic run_frame(input int lines, input int shortLine, input bit expValid,
                           input int vsEarlyAt, input int stopV, input int stopH);
    bit   ev;
    pix_t p;
    ev = expValid;
    for (int v = 0; v < lines; v++) begin
      for (int h = 0; h < ((v == shortLine) ? HTot - 1 : HTot); h++) begin
        logic       hs, vs;
        logic [7:0] col;
        bit         vis;
        hs  = (h < HSync);
        vs  = (v < VSync) || (v == lines - 1 && vsEarlyAt >= 0 && h >= vsEarlyAt);
        vis = (h >= HStart) && (h < HStart + HVis) && (v >= VStart) && (v < VStart + VVis);
        col = vis ? (8'hA5 ^ 8'((h - HStart) + 16 * (v - VStart))) : 8'(h + v);
        drive(hs, vs, col);
        if (h == 0 && v == 0) frameLaunch = cycle;
        if (vis && ev) begin
          p.x      = 10'(h - HStart);
          p.y      = 10'(v - VStart);
          p.c      = col;
          p.launch = cycle;
          pixQ.push_back(p);
        end
        if (v == stopV && h == stopH) return;
      end
      if (v == shortLine) ev = 1'b0;
    end
  endtask

  task automatic test_reset();
    bus.HSYNC_IN = 1'b0;
    bus.VSYNC_IN = 1'b0;
    bus.COLOR_IN = 8'h00;
    RESET = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    assertCount++;
    if ({bus.X_PIXEL, bus.Y_PIXEL, bus.COLOR_OUT} !== 28'd0) begin
      failCount++;
      $display("FAIL reset_xyc: got %h required 0", {bus.X_PIXEL, bus.Y_PIXEL, bus.COLOR_OUT});
    end
    assertCount++;
    if ({bus.PIXEL_VALID, bus.LINE_START, bus.FRAME_START, bus.LOCKED, bus.H_ERR, bus.V_ERR}
        !== 6'd0) begin
      failCount++;
      $display("FAIL reset_flags: got %b required 000000", {bus.PIXEL_VALID, bus.LINE_START,
               bus.FRAME_START, bus.LOCKED, bus.H_ERR, bus.V_ERR});
    end
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  task automatic test_clean_lock();
    run_frame(VTot, -1, 1'b0, -1, -1, -1);
    assertCount++;
    if (validCount !== 0 || bus.LOCKED !== 1'b0) begin
      failCount++;
      $display("FAIL frame1_idle: valid=%0d locked=%b required 0/0", validCount, bus.LOCKED);
    end
    run_frame(VTot, -1, 1'b1, -1, -1, -1);
    assertCount++;
    if (lockRiseFrame !== 2 || bus.LOCKED !== 1'b1) begin
      failCount++;
      $display("FAIL lock_at_2nd: rise_frame=%0d locked=%b required 2/1", lockRiseFrame,
               bus.LOCKED);
    end
    run_frame(VTot, -1, 1'b1, -1, -1, -1);
    assertCount++;
    if (hErrCount !== 0 || vErrCount !== 0) begin
      failCount++;
      $display("FAIL clean_errs: h=%0d v=%0d required 0/0", hErrCount, vErrCount);
    end
    assertCount++;
    if (frameStartCount !== 3 || lineStartCount !== 3 * VTot) begin
      failCount++;
      $display("FAIL clean_counts: fs=%0d ls=%0d required 3/%0d", frameStartCount,
               lineStartCount, 3 * VTot);
    end
    assertCount++;
    if (lastFrameStartCycle - frameLaunch !== 2) begin
      failCount++;
      $display("FAIL frame_start_lat: got %0d required 2", lastFrameStartCycle - frameLaunch);
    end
  endtask

  task automatic test_pixels();
    int base;
    base      = validCount;
    firstSeen = 1'b0;
    run_frame(VTot, -1, 1'b1, -1, -1, -1);
    assertCount++;
    if (validCount - base !== HVis * VVis) begin
      failCount++;
      $display("FAIL strobe_count: got %0d required %0d", validCount - base, HVis * VVis);
    end
    assertCount++;
    if (firstX !== 10'd0 || firstY !== 10'd0 || firstColor !== 8'hA5) begin
      failCount++;
      $display("FAIL first_pixel: x=%0d y=%0d c=%h required 0 0 a5", firstX, firstY, firstColor);
    end
    assertCount++;
    if (lastX !== 10'(HVis - 1) || lastY !== 10'(VVis - 1)) begin
      failCount++;
      $display("FAIL last_pixel: x=%0d y=%0d required %0d %0d", lastX, lastY, HVis - 1,
               VVis - 1);
    end
    assertCount++;
    if (pixQ.size() !== 0) begin
      failCount++;
      $display("FAIL pixels_missing: %0d left required 0", pixQ.size());
      pixQ.delete();
    end
  endtask

  task automatic test_vsync_midline();
    int fs, he, ve;
    fs = frameStartCount;
    he = hErrCount;
    ve = vErrCount;
    run_frame(VTot, -1, 1'b1, HTot / 2, -1, -1);
    assertCount++;
    if (frameStartCount - fs !== 1) begin
      failCount++;
      $display("FAIL vs_midline_early: frame starts %0d required 1", frameStartCount - fs);
    end
    run_frame(VTot, -1, 1'b1, -1, -1, -1);
    assertCount++;
    if (frameStartCount - fs !== 2 || lastFrameStartCycle - frameLaunch !== 2) begin
      failCount++;
      $display("FAIL vs_midline_align: starts=%0d lat=%0d required 2/2", frameStartCount - fs,
               lastFrameStartCycle - frameLaunch);
    end
    assertCount++;
    if (hErrCount !== he || vErrCount !== ve || bus.LOCKED !== 1'b1) begin
      failCount++;
      $display("FAIL vs_midline_lock: h=%0d v=%0d locked=%b required %0d %0d 1", hErrCount,
               vErrCount, bus.LOCKED, he, ve);
    end
  endtask

  task automatic test_short_line();
    int fs, he, ve;
    fs = frameStartCount;
    he = hErrCount;
    ve = vErrCount;
    run_frame(VTot, 5, 1'b1, -1, -1, -1);
    assertCount++;
    if (hErrCount - he !== 1 || bus.LOCKED !== 1'b0) begin
      failCount++;
      $display("FAIL short_line_err: h=%0d locked=%b required 1/0", hErrCount - he, bus.LOCKED);
    end
    run_frame(VTot, -1, 1'b0, -1, -1, -1);
    run_frame(VTot, -1, 1'b1, -1, -1, -1);
    assertCount++;
    if (lockRiseFrame - fs !== 3 || bus.LOCKED !== 1'b1 || vErrCount !== ve) begin
      failCount++;
      $display("FAIL short_line_relock: frame=%0d locked=%b v=%0d required 3 1 %0d",
               lockRiseFrame - fs, bus.LOCKED, vErrCount, ve);
    end
  endtask

  task automatic test_short_frame();
    int fs, he, ve;
    fs = frameStartCount;
    he = hErrCount;
    ve = vErrCount;
    run_frame(VTot - 1, -1, 1'b1, -1, -1, -1);
    run_frame(VTot, -1, 1'b0, -1, -1, -1);
    assertCount++;
    if (vErrCount - ve !== 1 || hErrCount !== he || bus.LOCKED !== 1'b0) begin
      failCount++;
      $display("FAIL short_frame_err: v=%0d h=%0d locked=%b required 1 0 0", vErrCount - ve,
               hErrCount - he, bus.LOCKED);
    end
    run_frame(VTot, -1, 1'b1, -1, -1, -1);
    assertCount++;
    if (lockRiseFrame - fs !== 3 || bus.LOCKED !== 1'b1) begin
      failCount++;
      $display("FAIL short_frame_relock: frame=%0d locked=%b required 3/1", lockRiseFrame - fs,
               bus.LOCKED);
    end
  endtask

  task automatic test_hsync_loss();
    int fs, he, ve;
    fs = frameStartCount;
    he = hErrCount;
    ve = vErrCount;
    for (int i = 0; i < 3000; i++) drive(1'b0, 1'b0, 8'h3C);
    assertCount++;
    if (hErrCount !== he || bus.LOCKED !== 1'b1) begin
      failCount++;
      $display("FAIL hold_quiet: h=%0d locked=%b required 0/1", hErrCount - he, bus.LOCKED);
    end
    run_frame(VTot, -1, 1'b0, -1, -1, -1);
    assertCount++;
    if (hErrCount - he !== 1 || vErrCount !== ve) begin
      failCount++;
      $display("FAIL saturate_err: h=%0d v=%0d required 1/0", hErrCount - he, vErrCount - ve);
    end
    run_frame(VTot, -1, 1'b1, -1, -1, -1);
    assertCount++;
    if (lockRiseFrame - fs !== 2 || bus.LOCKED !== 1'b1) begin
      failCount++;
      $display("FAIL saturate_relock: frame=%0d locked=%b required 2/1", lockRiseFrame - fs,
               bus.LOCKED);
    end
  endtask

  task automatic test_reset_midframe();
    int fs, he, ve;
    run_frame(VTot, -1, 1'b1, -1, VStart + 3, HStart + 4);
    @(posedge CLK);
    @(posedge CLK);
    #2;
    assertCount++;
    if (bus.X_PIXEL !== 10'd4 || bus.Y_PIXEL !== 10'd3 || bus.PIXEL_VALID !== 1'b1) begin
      failCount++;
      $display("FAIL pre_reset_pixel: x=%0d y=%0d v=%b required 4 3 1", bus.X_PIXEL,
               bus.Y_PIXEL, bus.PIXEL_VALID);
    end
    RESET = 1'b1;
    #1;
    assertCount++;
    if ({bus.X_PIXEL, bus.Y_PIXEL, bus.COLOR_OUT, bus.PIXEL_VALID, bus.LOCKED} !== 30'd0) begin
      failCount++;
      $display("FAIL async_reset: x=%0d y=%0d c=%h v=%b l=%b required all 0", bus.X_PIXEL,
               bus.Y_PIXEL, bus.COLOR_OUT, bus.PIXEL_VALID, bus.LOCKED);
    end
    pixQ.delete();
    repeat (3) @(posedge CLK);
    #1;
    bus.HSYNC_IN = 1'b0;
    bus.VSYNC_IN = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    fs = frameStartCount;
    he = hErrCount;
    ve = vErrCount;
    run_frame(VTot, -1, 1'b0, -1, -1, -1);
    run_frame(VTot, -1, 1'b1, -1, -1, -1);
    assertCount++;
    if (lockRiseFrame - fs !== 2 || bus.LOCKED !== 1'b1 || hErrCount !== he ||
        vErrCount !== ve) begin
      failCount++;
      $display("FAIL reset_relock: frame=%0d locked=%b h=%0d v=%0d required 2 1 0 0",
               lockRiseFrame - fs, bus.LOCKED, hErrCount - he, vErrCount - ve);
    end
    assertCount++;
    if (pixQ.size() !== 0) begin
      failCount++;
      $display("FAIL reset_pixels_missing: %0d left required 0", pixQ.size());
    end
  endtask

  initial begin
    #500000;
    failCount++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_lock();
    test_pixels();
    test_vsync_midline();
    test_short_line();
    test_short_frame();
    test_hsync_loss();
    test_reset_midframe();
    repeat (4) @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
